// File: rtl/pc_fetch_pkg.sv
// Shared widths, reset PC and fetch FSM encoding for the program-counter fetch controller.
package pc_fetch_pkg;

    localparam int PC_W = 12;
    localparam int INSN_W = 32;
    localparam logic [PC_W-1:0] RESET_PC = 12'h000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

endpackage

// File: rtl/pc_fetch_skid.sv
// One-entry skid register holding {insn, pc} while decode is stalled.
module pc_fetch_skid #(
    parameter int PC_W   = pc_fetch_pkg::PC_W,
    parameter int INSN_W = pc_fetch_pkg::INSN_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic              flush_i,
    input  logic [INSN_W-1:0] insn_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              full_o,
    output logic [INSN_W-1:0] insn_o,
    output logic [PC_W-1:0]   pc_o
);

    logic              full_q;
    logic [INSN_W-1:0] insn_q;
    logic [PC_W-1:0]   pc_q;

    // Flush wins over a simultaneous load so a redirected response never lingers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            insn_q <= '0;
            pc_q   <= '0;
        end else if (flush_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q <= 1'b1;
            insn_q <= insn_i;
            pc_q   <= pc_i;
        end else if (drain_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign insn_o = insn_q;
    assign pc_o   = pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and fetch-to-decode handshake with skid buffer and redirect flush.
// Define PC_WRAP_TRAP_EN to halt fetch (sticky wrap_err) after fetching the last PC.
module pc_fetch_ctrl #(
    parameter int              PC_W     = pc_fetch_pkg::PC_W,
    parameter int              INSN_W   = pc_fetch_pkg::INSN_W,
    parameter logic [PC_W-1:0] RESET_PC = pc_fetch_pkg::RESET_PC
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INSN_W-1:0] imem_q,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_target,
    output logic              fd_valid,
    input  logic              fd_ready,
    output logic [INSN_W-1:0] fd_insn,
    output logic [31:0]       fd_pc,
    output logic [31:0]       fd_pc_plus1,
    output logic              wrap_err
);
    import pc_fetch_pkg::*;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, inflight_pc_q, fd_pc_q, fd_pc_inc;
    logic              inflight_q, fd_valid_q;
    logic [INSN_W-1:0] fd_insn_q, skid_insn;
    logic [PC_W-1:0]   skid_pc;
    logic              skid_full, skid_load, skid_drain, stall, out_free;

    assign stall    = fd_valid_q & ~fd_ready;
    assign out_free = ~fd_valid_q | fd_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
`ifdef PC_WRAP_TRAP_EN
                if (imem_req && pc_q == '1) state_d = HALT;
`endif
            end
            HALT: if (redirect_valid) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        wrap_err = 1'b0;
        case (state_q)
            RUN: imem_req = ~redirect_valid & ~skid_full & ~(inflight_q & stall);
`ifdef PC_WRAP_TRAP_EN
            HALT: wrap_err = 1'b1;
`endif
            default: ;
        endcase
    end

    // A response that cannot reach the stalled output register parks in the skid.
    assign skid_load  = ~redirect_valid & inflight_q & stall;
    assign skid_drain = ~redirect_valid & fd_valid_q & fd_ready;

    pc_fetch_skid #(.PC_W(PC_W), .INSN_W(INSN_W)) u_skid (
        .clock   (clock),
        .reset   (reset),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .flush_i (redirect_valid),
        .insn_i  (imem_q),
        .pc_i    (inflight_pc_q),
        .full_o  (skid_full),
        .insn_o  (skid_insn),
        .pc_o    (skid_pc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            fd_valid_q    <= 1'b0;
            fd_insn_q     <= '0;
            fd_pc_q       <= '0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) inflight_pc_q <= pc_q;

            if (redirect_valid) pc_q <= redirect_target;
            else if (imem_req)  pc_q <= pc_q + PC_W'(1);

            // Skid content is older than any arriving response, so it goes out first.
            if (redirect_valid) begin
                fd_valid_q <= 1'b0;
            end else if (out_free) begin
                if (skid_full) begin
                    fd_valid_q <= 1'b1;
                    fd_insn_q  <= skid_insn;
                    fd_pc_q    <= skid_pc;
                end else if (inflight_q) begin
                    fd_valid_q <= 1'b1;
                    fd_insn_q  <= imem_q;
                    fd_pc_q    <= inflight_pc_q;
                end else begin
                    fd_valid_q <= 1'b0;
                end
            end
        end
    end

    assign fd_pc_inc   = fd_pc_q + PC_W'(1);
    assign imem_addr   = pc_q;
    assign fd_valid    = fd_valid_q;
    assign fd_insn     = fd_insn_q;
    assign fd_pc       = {{(32-PC_W){1'b0}}, fd_pc_q};
    assign fd_pc_plus1 = {{(32-PC_W){1'b0}}, fd_pc_inc};

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: stream, backpressure, redirects, wrap and async reset.
module tb_pc_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [31:0] imem_q = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_target = 12'h000;
    logic        fd_valid;
    logic        fd_ready = 1'b0;
    logic [31:0] fd_insn, fd_pc, fd_pc_plus1;
    logic        wrap_err;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_pc = 12'h000;

    always #5 clock = ~clock;

    pc_fetch_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_q          (imem_q),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fd_valid        (fd_valid),
        .fd_ready        (fd_ready),
        .fd_insn         (fd_insn),
        .fd_pc           (fd_pc),
        .fd_pc_plus1     (fd_pc_plus1),
        .wrap_err        (wrap_err)
    );

    // Synchronous instruction memory: data tags its own address.
    always @(posedge clock) imem_q <= 32'hA5A5_0000 ^ {20'h0, imem_addr};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic expect_fd(input string tag, input logic [11:0] pc);
        logic [11:0] p1;
        p1 = pc + 12'h1;
        chk({tag, "_vld"}, 32'(fd_valid), 32'd1);
        chk({tag, "_pc"}, fd_pc, {20'h0, pc});
        chk({tag, "_pc1"}, fd_pc_plus1, {20'h0, p1});
        chk({tag, "_insn"}, fd_insn, 32'hA5A5_0000 ^ {20'h0, pc});
    endtask

    task automatic expect_req(input string tag, input logic [11:0] addr);
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, 32'(imem_addr), {20'h0, addr});
    endtask

    // Every accepted payload must be the next pc in program order (reset/redirect restart it).
    always @(negedge clock) begin
        if (reset) begin
            exp_pc <= 12'h000;
        end else begin
            if (fd_valid && fd_ready) begin
                chk("order_pc", fd_pc, {20'h0, exp_pc});
                chk("order_insn", fd_insn, 32'hA5A5_0000 ^ fd_pc);
                exp_pc <= fd_pc[11:0] + 12'h1;
            end
            if (redirect_valid) exp_pc <= redirect_target;
        end
    end

    initial begin
        cyc(); cyc(); #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_vld", 32'(fd_valid), 32'd0);
        chk("rst_insn", fd_insn, 32'd0);
        chk("rst_pc", fd_pc, 32'd0);
        chk("rst_pc1", fd_pc_plus1, 32'd1);
        chk("rst_werr", 32'(wrap_err), 32'd0);
        reset = 1'b0; fd_ready = 1'b1; #1;
        chk("idle_req", 32'(imem_req), 32'd0);

        // Streaming with fd_ready=1
        for (int n = 1; n <= 5; n++) begin
            cyc(); #1;
            expect_req("run", 12'(n - 1));
            if (n >= 3) expect_fd("run_fd", 12'(n - 3));
            else chk("run_vld0", 32'(fd_valid), 32'd0);
        end

        // Backpressure: four stalled cycles with pc 3 on the output
        cyc(); fd_ready = 1'b0; #1;
        expect_fd("bp_hold", 12'h003);
        chk("bp_req", 32'(imem_req), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            expect_fd("bp_hold", 12'h003);
            chk("bp_req", 32'(imem_req), 32'd0);
            chk("bp_skid_full", 32'(dut.u_skid.full_o), 32'd1);
            chk("bp_skid_pc", 32'(dut.u_skid.pc_o), 32'd4);
        end
        cyc(); fd_ready = 1'b1; #1;
        expect_fd("rel_3", 12'h003);
        chk("rel_req", 32'(imem_req), 32'd0);
        cyc(); #1;
        expect_fd("rel_4", 12'h004);
        expect_req("rel_a5", 12'h005);
        cyc(); #1;
        expect_req("rel_a6", 12'h006);
        cyc(); #1;
        expect_fd("rel_5", 12'h005);
        expect_req("rel_a7", 12'h007);

        // Redirect while stalled with the skid full
        cyc(); fd_ready = 1'b0; #1;
        expect_fd("pre_rd", 12'h006);
        cyc(); #1;
        chk("pre_rd_skid", 32'(dut.u_skid.full_o), 32'd1);
        cyc(); redirect_valid = 1'b1; redirect_target = 12'h123; #1;
        chk("rd_noreq", 32'(imem_req), 32'd0);
        cyc(); redirect_valid = 1'b0; #1;
        chk("rd_vld0", 32'(fd_valid), 32'd0);
        chk("rd_skid0", 32'(dut.u_skid.full_o), 32'd0);
        expect_req("rd_t1", 12'h123);
        cyc(); #1;
        chk("rd_t2_vld", 32'(fd_valid), 32'd0);
        cyc(); fd_ready = 1'b1; #1;
        expect_fd("rd_t3", 12'h123);

        // Redirect on the cycle a response arrives
        cyc(); #1;
        expect_fd("rr_pre", 12'h124);
        cyc(); redirect_valid = 1'b1; redirect_target = 12'h200; #1;
        chk("rr_inflight", 32'(dut.inflight_q), 32'd1);
        cyc(); redirect_valid = 1'b0; #1;
        chk("rr_vld0", 32'(fd_valid), 32'd0);
        expect_req("rr_t1", 12'h200);
        cyc(); #1;
        chk("rr_t2_vld", 32'(fd_valid), 32'd0);
        cyc(); #1;
        expect_fd("rr_t3", 12'h200);

        // PC wrap
        cyc(); redirect_valid = 1'b1; redirect_target = 12'hFFE; #1;
        cyc(); redirect_valid = 1'b0; #1;
        expect_req("wr_ffe", 12'hFFE);
        cyc(); #1;
        expect_req("wr_fff", 12'hFFF);
        cyc(); #1;
        expect_fd("wr_fd_ffe", 12'hFFE);
`ifdef PC_WRAP_TRAP_EN
        chk("wr_halt_req", 32'(imem_req), 32'd0);
        chk("wr_werr", 32'(wrap_err), 32'd1);
`else
        expect_req("wr_000", 12'h000);
        chk("wr_werr", 32'(wrap_err), 32'd0);
`endif
        cyc(); #1;
        expect_fd("wr_fd_fff", 12'hFFF);
        cyc(); #1;
`ifdef PC_WRAP_TRAP_EN
        chk("wr_drained", 32'(fd_valid), 32'd0);
        chk("wr_halt_req2", 32'(imem_req), 32'd0);
        cyc(); #1;
        chk("wr_werr_sticky", 32'(wrap_err), 32'd1);
        chk("wr_halt_req3", 32'(imem_req), 32'd0);
`else
        expect_fd("wr_fd_000", 12'h000);
        cyc(); #1;
`endif
        cyc(); redirect_valid = 1'b1; redirect_target = 12'h010; #1;
        cyc(); redirect_valid = 1'b0; #1;
        chk("wr_werr_clr", 32'(wrap_err), 32'd0);
        expect_req("wr_rd", 12'h010);
        cyc(); cyc(); #1;
        expect_fd("wr_rd_fd", 12'h010);

        // Asynchronous reset mid-cycle during streaming
        cyc(); #1;
        reset = 1'b1; #1;
        chk("ar_req", 32'(imem_req), 32'd0);
        chk("ar_addr", 32'(imem_addr), 32'd0);
        chk("ar_vld", 32'(fd_valid), 32'd0);
        chk("ar_insn", fd_insn, 32'd0);
        chk("ar_pc", fd_pc, 32'd0);
        chk("ar_pc1", fd_pc_plus1, 32'd1);
        chk("ar_werr", 32'(wrap_err), 32'd0);
        cyc(); reset = 1'b0; #1;
        chk("ar_idle_req", 32'(imem_req), 32'd0);
        cyc(); #1;
        expect_req("ar_r1", 12'h000);
        cyc(); #1;
        chk("ar_r2_vld", 32'(fd_valid), 32'd0);
        cyc(); #1;
        expect_fd("ar_fd", 12'h000);

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
